// File: rtl/wb_stage.sv
// Write-back stage: selects the result for the register file, waits on load
// data when needed, extracts and sign-extends loads, and counts retirements.
module wb_stage #(
  parameter int XLEN         = 32,
  parameter int RETIRE_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             inst,
  input  logic [XLEN-1:0]         pc,
  input  logic [XLEN-1:0]         imm,
  input  logic [XLEN-1:0]         alu_out,
  input  logic [XLEN-1:0]         mem_addr,
  input  logic                    dmem_rvalid,
  input  logic [XLEN-1:0]         dmem_rdata,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  output logic                    fwd_valid,
  output logic [4:0]              fwd_rd,
  output logic [XLEN-1:0]         fwd_data,
  output logic                    load_misaligned,
  output logic [RETIRE_CNT_W-1:0] retired
);
  localparam int OFFW = $clog2(XLEN/8);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IOP   = 7'b0010011;
  localparam logic [6:0] OP_ROP   = 7'b0110011;

  typedef enum logic {IDLE, WAIT_LOAD} state_e;

  state_e                  state_q;
  logic                    rf_we_q, mis_q;
  logic [4:0]              rf_waddr_q;
  logic [XLEN-1:0]         rf_wdata_q;
  logic [RETIRE_CNT_W-1:0] retired_q;
  logic [4:0]              ld_rd_q;
  logic [2:0]              ld_f3_q;
  logic [OFFW-1:0]         ld_off_q;

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      f3;
  logic            is_load, writes, ld_done, ld_ok;
  logic [XLEN-1:0] res, ld_val, sh;
  logic [4:0]      ex_rd;
  logic [2:0]      ex_f3;
  logic [OFFW-1:0] ex_off;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign f3     = inst[14:12];
  assign is_load = (opcode == OP_LOAD);

  // Upper instruction bits and the aligned part of the address are not needed here.
  logic unused_bits;
  assign unused_bits = ^{inst[31:15], mem_addr[XLEN-1:OFFW]};

  // Non-load result selection; sums wrap naturally at XLEN bits.
  always_comb begin
    res    = alu_out;
    writes = 1'b0;
    case (opcode)
      OP_LUI:          begin res = imm;            writes = 1'b1; end
      OP_AUIPC:        begin res = pc + imm;       writes = 1'b1; end
      OP_JAL, OP_JALR: begin res = pc + XLEN'(4);  writes = 1'b1; end
      OP_IOP, OP_ROP:  begin res = alu_out;        writes = 1'b1; end
      default:         begin res = alu_out;        writes = 1'b0; end
    endcase
  end

  // A load completes either in the same cycle it is accepted or later from WAIT_LOAD;
  // the extraction fields come from the live instruction or the latched copy accordingly.
  always_comb begin
    ld_done = (state_q == IDLE) ? (in_valid && is_load && dmem_rvalid)
                                : dmem_rvalid;
    ex_rd  = (state_q == IDLE) ? rd : ld_rd_q;
    ex_f3  = (state_q == IDLE) ? f3 : ld_f3_q;
    ex_off = (state_q == IDLE) ? mem_addr[OFFW-1:0] : ld_off_q;
  end

  // Little-endian extraction: shift the addressed byte down to bit 0, then size/extend.
  always_comb begin
    sh     = dmem_rdata >> {ex_off, 3'b000};
    ld_ok  = 1'b1;
    ld_val = '0;
    case (ex_f3)
      3'b000: ld_val = XLEN'($signed(sh[7:0]));
      3'b100: ld_val = XLEN'(sh[7:0]);
      3'b001: begin ld_val = XLEN'($signed(sh[15:0])); ld_ok = ~ex_off[0]; end
      3'b101: begin ld_val = XLEN'(sh[15:0]);          ld_ok = ~ex_off[0]; end
      3'b010: begin ld_val = XLEN'($signed(sh[31:0])); ld_ok = (ex_off[1:0] == 2'b00); end
      3'b110: begin ld_val = XLEN'(sh[31:0]);
                    ld_ok  = (XLEN == 64) && (ex_off[1:0] == 2'b00); end
      3'b011: begin ld_val = sh; ld_ok = (XLEN == 64) && (ex_off == '0); end
      default: ld_ok = 1'b0;
    endcase
  end

  // FSM plus registered write port, misalignment pulse and retirement counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rf_we_q    <= 1'b0;
      mis_q      <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      retired_q  <= '0;
      ld_rd_q    <= '0;
      ld_f3_q    <= '0;
      ld_off_q   <= '0;
    end else begin
      rf_we_q <= 1'b0;
      mis_q   <= 1'b0;
      if (ld_done) begin
        retired_q <= retired_q + RETIRE_CNT_W'(1);
        if (!ld_ok) begin
          mis_q <= 1'b1;
        end else if (ex_rd != 5'd0) begin
          rf_we_q    <= 1'b1;
          rf_waddr_q <= ex_rd;
          rf_wdata_q <= ld_val;
        end
      end
      case (state_q)
        IDLE: begin
          if (in_valid && !is_load) begin
            retired_q <= retired_q + RETIRE_CNT_W'(1);
            if (writes && rd != 5'd0) begin
              rf_we_q    <= 1'b1;
              rf_waddr_q <= rd;
              rf_wdata_q <= res;
            end
          end else if (in_valid && is_load && !dmem_rvalid) begin
            ld_rd_q  <= rd;
            ld_f3_q  <= f3;
            ld_off_q <= mem_addr[OFFW-1:0];
            state_q  <= WAIT_LOAD;
          end
        end
        WAIT_LOAD: if (dmem_rvalid) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign in_ready        = (state_q == IDLE);
  assign rf_we           = rf_we_q;
  assign rf_waddr        = rf_waddr_q;
  assign rf_wdata        = rf_wdata_q;
  assign fwd_valid       = rf_we_q;
  assign fwd_rd          = rf_waddr_q;
  assign fwd_data        = rf_wdata_q;
  assign load_misaligned = mis_q;
  assign retired         = retired_q;
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: a 32-bit instance and a 64-bit instance (4-bit retire
// counter, so wrap is exercised) share stimulus and are compared each cycle
// against a transaction-level reference model.
module tb_wb_stage;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
    JALR = 7'b1100111, LOAD = 7'b0000011, IOP = 7'b0010011, ROP = 7'b0110011,
    JUNK = 7'b1110011;

  logic clk = 1'b0;
  logic rst, in_valid, dmem_rvalid;
  logic [31:0] inst;
  logic [63:0] pc, imm, alu_out, mem_addr, dmem_rdata;

  logic        rdy32, we32, fv32, mis32;
  logic [4:0]  wa32, frd32;
  logic [31:0] wd32, fd32, ret32;
  logic        rdy64, we64, fv64, mis64;
  logic [4:0]  wa64, frd64;
  logic [63:0] wd64, fd64;
  logic [3:0]  ret64;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .RETIRE_CNT_W(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .inst(inst),
    .pc(pc[31:0]), .imm(imm[31:0]), .alu_out(alu_out[31:0]), .mem_addr(mem_addr[31:0]),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata[31:0]),
    .rf_we(we32), .rf_waddr(wa32), .rf_wdata(wd32),
    .fwd_valid(fv32), .fwd_rd(frd32), .fwd_data(fd32),
    .load_misaligned(mis32), .retired(ret32));

  wb_stage #(.XLEN(64), .RETIRE_CNT_W(4)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .inst(inst),
    .pc(pc), .imm(imm), .alu_out(alu_out), .mem_addr(mem_addr),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rf_we(we64), .rf_waddr(wa64), .rf_wdata(wd64),
    .fwd_valid(fv64), .fwd_rd(frd64), .fwd_data(fd64),
    .load_misaligned(mis64), .retired(ret64));

  // Reference model state; index 0 = 32-bit instance, 1 = 64-bit instance.
  bit          busy;
  logic [4:0]  p_rd;
  logic [2:0]  p_f3;
  logic [63:0] p_addr;
  logic        e_we[2], e_mis[2];
  logic [4:0]  e_wa[2];
  logic [63:0] e_wd[2], e_ret[2];

  function automatic logic [63:0] xmask(input int i);
    return (i == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  // Load extraction from first principles: gather n bytes little-endian.
  function automatic void ld_model(input int xl, input logic [2:0] f3, input logic [63:0] addr,
                                   input logic [63:0] data, output bit ok, output logic [63:0] val);
    int n, off;
    bit sgn;
    logic [63:0] v;
    n = 0; sgn = 0;
    case (f3)
      3'd0: begin n = 1; sgn = 1; end
      3'd4: n = 1;
      3'd1: begin n = 2; sgn = 1; end
      3'd5: n = 2;
      3'd2: begin n = 4; sgn = 1; end
      3'd6: n = (xl == 64) ? 4 : 0;
      3'd3: n = (xl == 64) ? 8 : 0;
      default: n = 0;
    endcase
    off = int'(addr % 64'(xl / 8));
    ok  = (n != 0) && (off % (n == 0 ? 1 : n) == 0);
    v = 64'd0;
    for (int k = 0; k < n; k++) v = v | (((data >> (8 * (off + k))) & 64'hFF) << (8 * k));
    if (ok && sgn && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    val = v & ((xl == 32) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF);
  endfunction

  task automatic complete(input logic [4:0] rd, input logic [2:0] f3, input logic [63:0] addr);
    bit ok;
    logic [63:0] v;
    for (int i = 0; i < 2; i++) begin
      e_ret[i] = e_ret[i] + 1;
      ld_model(i == 0 ? 32 : 64, f3, addr, dmem_rdata & xmask(i), ok, v);
      if (!ok) e_mis[i] = 1'b1;
      else if (rd != 0) begin e_we[i] = 1'b1; e_wa[i] = rd; e_wd[i] = v; end
    end
  endtask

  // Advance the model by one clock using the inputs as currently driven.
  task automatic model_cycle();
    logic [6:0] op;
    logic [4:0] rd;
    logic [63:0] r;
    bit w;
    op = inst[6:0]; rd = inst[11:7];
    if (rst) begin
      busy = 0;
      for (int i = 0; i < 2; i++) begin
        e_we[i] = 0; e_mis[i] = 0; e_wa[i] = 0; e_wd[i] = 0; e_ret[i] = 0;
      end
      return;
    end
    for (int i = 0; i < 2; i++) begin e_we[i] = 0; e_mis[i] = 0; end
    if (busy) begin
      if (dmem_rvalid) begin complete(p_rd, p_f3, p_addr); busy = 0; end
    end else if (in_valid) begin
      if (op == LOAD) begin
        if (dmem_rvalid) complete(rd, inst[14:12], mem_addr);
        else begin busy = 1; p_rd = rd; p_f3 = inst[14:12]; p_addr = mem_addr; end
      end else begin
        w = 1; r = alu_out;
        case (op)
          LUI:       r = imm;
          AUIPC:     r = pc + imm;
          JAL, JALR: r = pc + 64'd4;
          IOP, ROP:  r = alu_out;
          default:   w = 0;
        endcase
        for (int i = 0; i < 2; i++) begin
          e_ret[i] = e_ret[i] + 1;
          if (w && rd != 0) begin e_we[i] = 1; e_wa[i] = rd; e_wd[i] = r & xmask(i); end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rdy32", 64'(rdy32), 64'(!busy));  chk("rdy64", 64'(rdy64), 64'(!busy));
    chk("we32", 64'(we32), 64'(e_we[0]));  chk("we64", 64'(we64), 64'(e_we[1]));
    chk("wa32", 64'(wa32), 64'(e_wa[0]));  chk("wa64", 64'(wa64), 64'(e_wa[1]));
    chk("wd32", 64'(wd32), e_wd[0]);       chk("wd64", wd64, e_wd[1]);
    chk("mis32", 64'(mis32), 64'(e_mis[0])); chk("mis64", 64'(mis64), 64'(e_mis[1]));
    chk("ret32", 64'(ret32), e_ret[0] & 64'hFFFF_FFFF);
    chk("ret64", 64'(ret64), e_ret[1] & 64'hF);
    chk("fwd32", {27'd0, fv32, frd32, fd32}, {27'd0, e_we[0], e_wa[0], e_wd[0][31:0]});
    chk("fv64", 64'({fv64, frd64}), 64'({e_we[1], e_wa[1]}));
    chk("fd64", fd64, e_wd[1]);
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drv(input bit v, input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                     input logic [63:0] a_pc, input logic [63:0] a_imm, input logic [63:0] a_alu,
                     input logic [63:0] a_addr, input bit rv, input logic [63:0] rdata);
    in_valid = v; inst = {17'd0, f3, rd, op};
    pc = a_pc; imm = a_imm; alu_out = a_alu; mem_addr = a_addr;
    dmem_rvalid = rv; dmem_rdata = rdata;
    step();
  endtask

  initial begin
    logic [6:0] ops[8];
    logic [31:0] r;
    ops = '{LUI, AUIPC, JAL, JALR, LOAD, IOP, ROP, JUNK};
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'hFFFF);
    chk("reset_we", 64'(we32), 64'd0);
    chk("reset_ret", 64'(ret32), 64'd0);
    chk("reset_wd", 64'(wd32), 64'd0);
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_reset_rdy", 64'(rdy32), 64'd1);

    drv(1, LUI, 5, 0, 0, 64'h1234_5000, 0, 0, 0, 0);
    chk("lui_wd", 64'(wd32), 64'h1234_5000);
    chk("lui_wa", 64'(wa32), 64'd5);
    chk("lui_ret", 64'(ret32), 64'd1);

    drv(1, JAL, 1, 0, 64'h100, 0, 0, 0, 0, 0);
    chk("jal_wd", 64'(wd32), 64'h104);
    drv(1, ROP, 2, 0, 0, 0, 64'h7, 0, 0, 0);
    chk("rop_b2b_wd", 64'(wd32), 64'h7);
    chk("rop_b2b_we", 64'(we32), 64'd1);

    drv(1, LOAD, 3, 3'b000, 0, 0, 0, 64'h1003, 0, 0);
    chk("lb_wait_rdy", 64'(rdy32), 64'd0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(1, ROP, 4, 0, 0, 0, 64'h55, 0, 0, 0);
    chk("lb_wait_rdy3", 64'(rdy32), 64'd0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h80FF_FFFF);
    chk("lb_wd32", 64'(wd32), 64'hFFFF_FF80);
    chk("lb_wd64", wd64, 64'hFFFF_FFFF_FFFF_FF80);

    drv(1, LOAD, 4, 3'b100, 0, 0, 0, 64'h1003, 1, 64'h80FF_FFFF);
    chk("lbu_wd32", 64'(wd32), 64'h80);
    chk("lbu_same_cycle_rdy", 64'(rdy32), 64'd1);

    drv(1, LOAD, 6, 3'b010, 0, 0, 0, 64'h2002, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h1234_5678);
    chk("lw_mis_pulse", 64'(mis32), 64'd1);
    chk("lw_mis_we", 64'(we32), 64'd0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lw_mis_one_cycle", 64'(mis32), 64'd0);

    drv(1, ROP, 0, 0, 0, 0, 64'h99, 0, 0, 0);
    chk("rd0_we", 64'(we32), 64'd0);
    drv(1, JUNK, 9, 0, 0, 0, 64'h99, 0, 0, 0);
    drv(1, AUIPC, 10, 0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 0, 0, 0, 0);
    chk("auipc_wrap32", 64'(wd32), 64'h10);

    drv(1, LOAD, 7, 3'b010, 0, 0, 0, 64'h0, 0, 0);
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    chk("rst_wait_ret", 64'(ret32), 64'd0);
    chk("rst_wait_rdy", 64'(rdy32), 64'd1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'hDEAD_BEEF);
    chk("stray_rvalid_we", 64'(we32), 64'd0);
    chk("stray_rvalid_ret", 64'(ret32), 64'd0);

    drv(1, LOAD, 8, 3'b011, 0, 0, 0, 64'h8, 1, 64'h8000_0000_0000_0001);
    chk("ld64_wd", wd64, 64'h8000_0000_0000_0001);
    chk("ld32_illegal", 64'(mis32), 64'd1);
    drv(1, LOAD, 9, 3'b010, 0, 0, 0, 64'h0, 1, 64'h8000_0000);
    chk("lw64_sext", wd64, 64'hFFFF_FFFF_8000_0000);

    for (int n = 0; n < 800; n++) begin
      r = $urandom;
      rst         = ($urandom_range(0, 99) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      inst        = {r[31:15], 3'($urandom_range(0, 7)),
                     ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                     ($urandom_range(0, 2) == 0) ? LOAD : ops[$urandom_range(0, 7)]};
      pc          = {$urandom, $urandom};
      imm         = {$urandom, $urandom};
      alu_out     = {$urandom, $urandom};
      mem_addr    = {$urandom, $urandom};
      dmem_rvalid = ($urandom_range(0, 2) == 0);
      dmem_rdata  = {$urandom, $urandom};
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
